// File: rtl/xs_tile_row_fetcher.sv
// Background tile-row fetcher: reads each tile row from SDRAM one 16-bit word at a time,
// queues assembled rows and serialises pixels. Optional WAIT watchdog: BG_FETCH_TIMEOUT_EN.
module xs_tile_row_fetcher #(
  parameter int          PIX_BITS  = 4,
  parameter int          TILE_W    = 16,
  parameter int          CODE_W    = 11,
  parameter int          ROW_W     = 4,
  parameter int          PAL_W     = 3,
  parameter int          DEPTH     = 4,
  parameter logic [24:0] BASE_ADDR = 25'h0,
  parameter int          TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                tile_valid,
  output logic                tile_ready,
  input  logic [CODE_W-1:0]   tile_code,
  input  logic [ROW_W-1:0]    tile_row,
  input  logic                tile_flipx,
  input  logic [PAL_W-1:0]    tile_pal,
  output logic [24:0]         sdr_addr,
  output logic                sdr_req,
  input  logic                sdr_rdy,
  input  logic [15:0]         sdr_data,
  input  logic                pix_en,
  output logic [PIX_BITS-1:0] pix_color,
  output logic [PAL_W-1:0]    pix_pal,
  output logic                pix_valid,
  output logic                underrun
);
  localparam int NW = TILE_W * PIX_BITS / 16;
  localparam int KB = (NW > 1) ? $clog2(NW) : 0;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int RB = TILE_W * PIX_BITS;
  localparam int PW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_STORE} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [ROW_W-1:0]    trow_q, trow_d;
  logic                flip_q, flip_d;
  logic [PAL_W-1:0]    pal_q, pal_d;
  logic [KW-1:0]       k_q, k_d;
  logic [RB-1:0]       row_q, row_d;
  logic                tile_ready_q, tile_ready_d;
  logic                sdr_req_q, sdr_req_d;
  logic [24:0]         sdr_addr_q, sdr_addr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       p_q, p_d;
  logic [PIX_BITS-1:0] pix_color_q, pix_color_d;
  logic [PAL_W-1:0]    pix_pal_q, pix_pal_d;
  logic                pix_valid_q, pix_valid_d;
  logic                underrun_q, underrun_d;

  logic [RB-1:0]       fifo_row  [DEPTH];
  logic                fifo_flip [DEPTH];
  logic [PAL_W-1:0]    fifo_pal  [DEPTH];

  logic                push, pop;
  logic [24:0]         word_off;
  logic [PW-1:0]       pix_idx;

`ifdef BG_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  // Fields never overlap BASE_ADDR's set bits, so OR-ing in the offset is carry-free.
  assign word_off = (25'(code_q) << (ROW_W + KB + 1)) | (25'(trow_q) << (KB + 1)) | (25'(k_q) << 1);
  assign pix_idx  = fifo_flip[rd_ptr_q] ? (PW'(TILE_W - 1) - p_q) : p_q;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    trow_d      = trow_q;
    flip_d      = flip_q;
    pal_d       = pal_q;
    k_d         = k_q;
    row_d       = row_q;
    sdr_req_d   = 1'b0;
    sdr_addr_d  = sdr_addr_q;
    push        = 1'b0;
    pop         = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    p_d         = p_q;
    pix_color_d = pix_color_q;
    pix_pal_d   = pix_pal_q;
    pix_valid_d = pix_valid_q;
    underrun_d  = underrun_q;
`ifdef BG_FETCH_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: if (tile_valid && tile_ready_q) begin
        code_d  = tile_code;
        trow_d  = tile_row;
        flip_d  = tile_flipx;
        pal_d   = tile_pal;
        k_d     = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        sdr_req_d  = 1'b1;
        sdr_addr_d = BASE_ADDR | word_off;
        state_d    = S_WAIT;
`ifdef BG_FETCH_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (sdr_rdy) begin
          row_d[{k_q, 4'b0} +: 16] = sdr_data;
          if (k_q == KW'(NW - 1)) state_d = S_STORE;
          else begin
            k_d     = k_q + KW'(1);
            state_d = S_REQ;
          end
        end
`ifdef BG_FETCH_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT)) state_d = S_REQ;
        else to_cnt_d = to_cnt_q + TW'(1);
`endif
      end
      S_STORE: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pix_en) begin
      if (count_q != '0) begin
        pix_color_d = fifo_row[rd_ptr_q][int'(pix_idx) * PIX_BITS +: PIX_BITS];
        pix_pal_d   = fifo_pal[rd_ptr_q];
        pix_valid_d = 1'b1;
        if (p_q == PW'(TILE_W - 1)) begin
          p_d = '0;
          pop = 1'b1;
        end else p_d = p_q + PW'(1);
      end else begin
        pix_color_d = '0;
        pix_valid_d = 1'b0;
        underrun_d  = 1'b1;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
    // Registered ready looks at next-cycle state so it never over-accepts.
    tile_ready_d = (state_d == S_IDLE) && (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      code_q       <= '0;
      trow_q       <= '0;
      flip_q       <= 1'b0;
      pal_q        <= '0;
      k_q          <= '0;
      row_q        <= '0;
      tile_ready_q <= 1'b0;
      sdr_req_q    <= 1'b0;
      sdr_addr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      p_q          <= '0;
      pix_color_q  <= '0;
      pix_pal_q    <= '0;
      pix_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef BG_FETCH_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      trow_q       <= trow_d;
      flip_q       <= flip_d;
      pal_q        <= pal_d;
      k_q          <= k_d;
      row_q        <= row_d;
      tile_ready_q <= tile_ready_d;
      sdr_req_q    <= sdr_req_d;
      sdr_addr_q   <= sdr_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      p_q          <= p_d;
      pix_color_q  <= pix_color_d;
      pix_pal_q    <= pix_pal_d;
      pix_valid_q  <= pix_valid_d;
      underrun_q   <= underrun_d;
`ifdef BG_FETCH_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_row[wr_ptr_q]  <= row_q;
      fifo_flip[wr_ptr_q] <= flip_q;
      fifo_pal[wr_ptr_q]  <= pal_q;
    end
  end

  assign tile_ready = tile_ready_q;
  assign sdr_req    = sdr_req_q;
  assign sdr_addr   = sdr_addr_q;
  assign pix_color  = pix_color_q;
  assign pix_pal    = pix_pal_q;
  assign pix_valid  = pix_valid_q;
  assign underrun   = underrun_q;
endmodule
